// File: rtl/hack_ps2_keyboard_if.sv
// hack_ps2_keyboard_if
// Groups the raw PS/2 pins and the Hack keyboard word outputs of the
// PS/2 keyboard receiver. The master side drives the pins (keyboard or
// bench); the slave side is the receiver itself.
interface hack_ps2_keyboard_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] kbd_code;
  logic        key_event;
  logic        frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  kbd_code,
    input  key_event,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output kbd_code,
    output key_event,
    output frame_err
  );
endinterface

// File: rtl/hack_ps2_keyboard.sv
// hack_ps2_keyboard
// PS/2 keyboard receiver and scan-code (set 2) translator producing the
// 16-bit Hack keyboard word (code of the held key, 0 when none).
// Frames are deserialised on synchronised ps2_clk falling edges, checked
// for start/parity/stop, and decoded with E0 (extended) and F0 (break)
// prefix tracking. A watchdog aborts frames that stall.
// Optional feature macro: HACK_KBD_SHIFT_EN -- tracks left/right shift
// and maps letters to lower case (97-122) unless shift is held.
module hack_ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset_n,
  hack_ps2_keyboard_if.slave kbd
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  // Scan-code lookup. Returns 0 for unmapped codes. Extended codes only
  // match the E0 table; plain codes only match the plain table.
  function automatic logic [7:0] map_code(input logic       ext,
                                          input logic [7:0] b,
                                          input logic       lower);
    logic [7:0] base;
    logic [7:0] code;
    base = lower ? 8'd97 : 8'd65;
    code = 8'd0;
    if (ext) begin
      case (b)
        8'h6B:   code = 8'd130;
        8'h75:   code = 8'd131;
        8'h74:   code = 8'd132;
        8'h72:   code = 8'd133;
        8'h6C:   code = 8'd134;
        8'h69:   code = 8'd135;
        8'h7D:   code = 8'd136;
        8'h7A:   code = 8'd137;
        8'h70:   code = 8'd138;
        8'h71:   code = 8'd139;
        default: code = 8'd0;
      endcase
    end else begin
      case (b)
        // letters A..Z
        8'h1C:   code = base + 8'd0;
        8'h32:   code = base + 8'd1;
        8'h21:   code = base + 8'd2;
        8'h23:   code = base + 8'd3;
        8'h24:   code = base + 8'd4;
        8'h2B:   code = base + 8'd5;
        8'h34:   code = base + 8'd6;
        8'h33:   code = base + 8'd7;
        8'h43:   code = base + 8'd8;
        8'h3B:   code = base + 8'd9;
        8'h42:   code = base + 8'd10;
        8'h4B:   code = base + 8'd11;
        8'h3A:   code = base + 8'd12;
        8'h31:   code = base + 8'd13;
        8'h44:   code = base + 8'd14;
        8'h4D:   code = base + 8'd15;
        8'h15:   code = base + 8'd16;
        8'h2D:   code = base + 8'd17;
        8'h1B:   code = base + 8'd18;
        8'h2C:   code = base + 8'd19;
        8'h3C:   code = base + 8'd20;
        8'h2A:   code = base + 8'd21;
        8'h1D:   code = base + 8'd22;
        8'h22:   code = base + 8'd23;
        8'h35:   code = base + 8'd24;
        8'h1A:   code = base + 8'd25;
        // digits 0..9
        8'h45:   code = 8'd48;
        8'h16:   code = 8'd49;
        8'h1E:   code = 8'd50;
        8'h26:   code = 8'd51;
        8'h25:   code = 8'd52;
        8'h2E:   code = 8'd53;
        8'h36:   code = 8'd54;
        8'h3D:   code = 8'd55;
        8'h3E:   code = 8'd56;
        8'h46:   code = 8'd57;
        // specials
        8'h29:   code = 8'd32;
        8'h5A:   code = 8'd128;
        8'h66:   code = 8'd129;
        8'h76:   code = 8'd140;
        // F1..F12
        8'h05:   code = 8'd141;
        8'h06:   code = 8'd142;
        8'h04:   code = 8'd143;
        8'h0C:   code = 8'd144;
        8'h03:   code = 8'd145;
        8'h0B:   code = 8'd146;
        8'h83:   code = 8'd147;
        8'h0A:   code = 8'd148;
        8'h01:   code = 8'd149;
        8'h09:   code = 8'd150;
        8'h78:   code = 8'd151;
        8'h07:   code = 8'd152;
        default: code = 8'd0;
      endcase
    end
    return code;
  endfunction

  // Input conditioning
  logic clk_meta_q,  clk_meta_d;
  logic clk_sync_q,  clk_sync_d;
  logic clk_prev_q,  clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;
  logic ps2_fall;

  // Receiver / decoder state
  state_t          state_q,     state_d;
  logic [3:0]      bit_cnt_q,   bit_cnt_d;
  logic [7:0]      shreg_q,     shreg_d;
  logic            parity_q,    parity_d;
  logic [7:0]      byte_q,      byte_d;
  logic [WD_W-1:0] wd_q,        wd_d;
  logic            ext_q,       ext_d;
  logic            brk_q,       brk_d;
  logic [7:0]      kbd_code_q,  kbd_code_d;
  logic            key_event_q, key_event_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      dec_code;
  logic            lower_case;
`ifdef HACK_KBD_SHIFT_EN
  logic            shift_q,     shift_d;
`endif

`ifdef HACK_KBD_SHIFT_EN
  assign lower_case = ~shift_q;
`else
  assign lower_case = 1'b0;
`endif

  assign ps2_fall = clk_prev_q & ~clk_sync_q;

  assign kbd.kbd_code  = {8'h00, kbd_code_q};
  assign kbd.key_event = key_event_q;
  assign kbd.frame_err = frame_err_q;

  // Two-flop synchronisers plus previous-value register for edge detection
  always_comb begin
    clk_meta_d  = kbd.ps2_clk;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = kbd.ps2_data;
    data_sync_d = data_meta_q;
  end

  // Synchroniser registers idle high, matching the released PS/2 bus
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  // Translate the received byte with the current prefix and shift state
  always_comb begin
    dec_code = map_code(ext_q, byte_q, lower_case);
  end

  // Receive FSM, watchdog, prefix tracking and key-code update
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    byte_d      = byte_q;
    wd_d        = wd_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    kbd_code_d  = kbd_code_q;
    frame_err_d = 1'b0;
`ifdef HACK_KBD_SHIFT_EN
    shift_d     = shift_q;
`endif

    if (ps2_fall) begin
      wd_d = '0;
    end else if (state_q == ST_RECV) begin
      wd_d = wd_q + WD_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (ps2_fall) begin
          if (!data_sync_q) begin
            state_d   = ST_RECV;
            bit_cnt_d = 4'd1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      ST_RECV: begin
        if (ps2_fall) begin
          if (bit_cnt_q <= 4'd8) begin
            shreg_d   = {data_sync_q, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd9) begin
            parity_d  = data_sync_q;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            // Stop bit: frame is good with stop=1 and odd overall parity
            if (data_sync_q && (^{shreg_q, parity_q})) begin
              byte_d  = shreg_q;
              state_d = ST_DECODE;
            end else begin
              frame_err_d = 1'b1;
              ext_d       = 1'b0;
              brk_d       = 1'b0;
              state_d     = ST_IDLE;
            end
          end
        end else if (wd_q == WD_LAST) begin
          frame_err_d = 1'b1;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
`ifdef HACK_KBD_SHIFT_EN
          if (!ext_q && (byte_q == 8'h12 || byte_q == 8'h59)) begin
            shift_d = ~brk_q;
          end
`endif
          if (dec_code != 8'd0) begin
            if (!brk_q) begin
              kbd_code_d = dec_code;
            end else if (kbd_code_q == dec_code) begin
              kbd_code_d = 8'd0;
            end
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A typematic repeat rewrites the same value and so raises no event
    key_event_d = (kbd_code_d != kbd_code_q);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'd0;
      parity_q    <= 1'b0;
      byte_q      <= 8'd0;
      wd_q        <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      kbd_code_q  <= 8'd0;
      key_event_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef HACK_KBD_SHIFT_EN
      shift_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      byte_q      <= byte_d;
      wd_q        <= wd_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      kbd_code_q  <= kbd_code_d;
      key_event_q <= key_event_d;
      frame_err_q <= frame_err_d;
`ifdef HACK_KBD_SHIFT_EN
      shift_q     <= shift_d;
`endif
    end
  end

endmodule
